// File: rtl/eth_pkg.sv
// Shared constants, FSM encoding and helpers for the Ethernet MAC blocks.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_OCTET = 8'h55;
    localparam logic [7:0]  SFD_OCTET      = 8'hD5;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY       = 32'h04C1_1DB7;

    localparam int ERR_W   = 3;
    localparam int ERR_CRC = 0;
    localparam int ERR_LEN = 1;
    localparam int ERR_PHY = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    // GMII delivers bit 0 first on the wire; the MSB-first CRC wants it first too.
    function automatic logic [7:0] bit_reverse8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

endpackage

// File: rtl/eth_mac_rx_l2_if.sv
// GMII receive pins plus the Avalon-ST source carrying checked frames.
interface eth_mac_rx_l2_if;
    import eth_pkg::*;

    logic [7:0]       ENET_RX_DATA;
    logic             ENET_RX_DV;
    logic             ENET_RX_ER;

    logic             out_valid;
    logic [7:0]       out_data;
    logic [7:0]       out_channel;
    logic             out_sop;
    logic             out_eop;
    logic [ERR_W-1:0] out_error;

    modport master (
        input  ENET_RX_DATA, ENET_RX_DV, ENET_RX_ER,
        output out_valid, out_data, out_channel, out_sop, out_eop, out_error
    );

    modport slave (
        output ENET_RX_DATA, ENET_RX_DV, ENET_RX_ER,
        input  out_valid, out_data, out_channel, out_sop, out_eop, out_error
    );

endinterface

// File: rtl/eth_crc32_d8.sv
// Registered CRC-32 (poly 0x04C11DB7, MSB-first), one octet per enabled cycle.
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        init,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ CRC_POLY;
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Rst_n)      crc <= CRC_INIT;
        else if (init)   crc <= CRC_INIT;
        else if (enable) crc <= crc_step(crc, data);
    end

endmodule

// File: rtl/eth_mac_rx_l2.sv
// GMII receive front end: preamble/SFD detect, FCS check and strip, Avalon-ST out.
module eth_mac_rx_l2
    import eth_pkg::*;
#(
    parameter logic [7:0] CHANNEL      = 8'd0,
    parameter int         MIN_PREAMBLE = 6,
    parameter int         MIN_FRAME    = 64,
    parameter int         MAX_FRAME    = 1518
) (
    input  logic              Clk,
    input  logic              Rst_n,
    eth_mac_rx_l2_if.master   bus,
    output logic [31:0]       frames_ok,
    output logic [31:0]       frames_bad
);

    localparam logic [2:0]  MIN_PRE = 3'(MIN_PREAMBLE);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

    rx_state_e        state, state_next;
    logic [2:0]       pre_cnt, pre_cnt_next;
    logic [15:0]      len, len_next;
    logic             phy_er, phy_er_next;
    logic             sop_pend, sop_pend_next;
    logic [4:0][7:0]  dly;
    logic [31:0]      crc;
    logic             crc_init, take;
    logic             emit, emit_eop;
    logic [ERR_W-1:0] emit_err;
    logic             cnt_ok, cnt_bad;

    logic             dv, er;
    logic [7:0]       rxd;

    assign dv  = bus.ENET_RX_DV;
    assign er  = bus.ENET_RX_ER;
    assign rxd = bus.ENET_RX_DATA;
    assign bus.out_channel = CHANNEL;

    eth_crc32_d8 u_crc (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .init   (crc_init),
        .enable (take),
        .data   (bit_reverse8(rxd)),
        .crc    (crc)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        pre_cnt_next  = pre_cnt;
        len_next      = len;
        phy_er_next   = phy_er;
        sop_pend_next = sop_pend;
        crc_init      = 1'b0;
        take          = 1'b0;
        emit          = 1'b0;
        emit_eop      = 1'b0;
        emit_err      = '0;
        cnt_ok        = 1'b0;
        cnt_bad       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (dv) begin
                    if (rxd == PREAMBLE_OCTET) begin
                        state_next   = ST_PREAMBLE;
                        pre_cnt_next = 3'd1;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!dv) begin
                    state_next = ST_IDLE;
                end else if (rxd == PREAMBLE_OCTET) begin
                    if (pre_cnt != 3'd7) pre_cnt_next = pre_cnt + 3'd1;
                end else if (rxd == SFD_OCTET && pre_cnt >= MIN_PRE) begin
                    state_next    = ST_DATA;
                    crc_init      = 1'b1;
                    len_next      = '0;
                    phy_er_next   = 1'b0;
                    sop_pend_next = 1'b1;
                end else begin
                    state_next = ST_DROP;
                    cnt_bad    = 1'b1;
                end
            end
            ST_DATA: begin
                if (dv) begin
                    take     = 1'b1;
                    len_next = len + 16'd1;
                    if (er) phy_er_next = 1'b1;
                    // Five octets held means the oldest is clear of the 4-octet FCS window.
                    if (len >= 16'd5) emit = 1'b1;
                    if (len == MAX_LEN) begin
                        emit_eop          = 1'b1;
                        emit_err[ERR_LEN] = 1'b1;
                        emit_err[ERR_PHY] = phy_er | er;
                        cnt_bad           = 1'b1;
                        state_next        = ST_DROP;
                    end
                end else begin
                    state_next = ST_IDLE;
                    if (len >= 16'd5) begin
                        emit              = 1'b1;
                        emit_eop          = 1'b1;
                        emit_err[ERR_CRC] = (crc != CRC_RESIDUE);
                        emit_err[ERR_LEN] = (len < MIN_LEN);
                        emit_err[ERR_PHY] = phy_er;
                        if (emit_err == '0) cnt_ok  = 1'b1;
                        else                cnt_bad = 1'b1;
                    end else begin
                        cnt_bad = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!dv) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (emit) sop_pend_next = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pre_cnt       <= '0;
            len           <= '0;
            phy_er        <= 1'b0;
            sop_pend      <= 1'b0;
            // NOTE: the delay line is small and cleared on reset so no stale octet survives an abort.
            dly           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_error <= '0;
            frames_ok     <= '0;
            frames_bad    <= '0;
        end else begin
            pre_cnt       <= pre_cnt_next;
            len           <= len_next;
            phy_er        <= phy_er_next;
            sop_pend      <= sop_pend_next;
            if (take) dly <= {dly[3:0], rxd};
            bus.out_valid <= emit;
            bus.out_data  <= emit ? dly[4] : 8'h00;
            bus.out_sop   <= emit & sop_pend;
            bus.out_eop   <= emit_eop;
            bus.out_error <= emit_err;
            if (cnt_ok)  frames_ok  <= frames_ok + 32'd1;
            if (cnt_bad) frames_bad <= frames_bad + 32'd1;
        end
    end

endmodule
